mem_stage_hs: RTL and testbench

Parametrised memory-access pipeline stage that sits between execute and writeback. It registers the execute-stage bundle and talks to an external variable-latency data memory through a valid/ready request channel and a valid response channel. It generates byte enables, formats load data, detects misaligned accesses, aborts hung loads with a timeout, and back-pressures execute while a memory transaction is in flight.

---
 rtl/mem_stage_hs.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory-access pipeline stage between execute and writeback.
// Registers the execute bundle, issues valid/ready requests to a
// variable-latency data memory, formats load data and aborts hung loads.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN (misaligned half/word
// accesses complete without a request and flag misalign_m).
module mem_stage_hs #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc_x,
  input  logic [31:0]       alu_x,
  input  logic [31:0]       rs2_x,
  input  logic [31:0]       inst_x,
  input  logic [31:0]       wb_w_bypass,
  input  logic              wm_bypass,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rsp_rdata,
  output logic              out_valid,
  output logic [31:0]       inst_m,
  output logic [31:0]       pc_m,
  output logic [31:0]       alu_m,
  output logic [31:0]       wb_m,
  output logic              misalign_m,
  output logic              timeout_m
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_m_q, inst_m_d;
  logic [31:0] pc_m_q, pc_m_d;
  logic [31:0] alu_m_q, alu_m_d;
  logic [31:0] rs2_m_q, rs2_m_d;
  logic [31:0] wb_m_q, wb_m_d;
  logic [31:0] sd_q, sd_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_first_q, req_first_d;
  logic        out_valid_q, out_valid_d;
  logic        misalign_m_q, misalign_m_d;
  logic        timeout_m_q, timeout_m_d;

  logic        is_mem_x, is_jump_x, mis_x, is_store_m;
  logic [1:0]  a_off, ld_off;
  logic [2:0]  funct3_m;
  logic [31:0] store_data, st_wdata, ld_shift, ld_fmt;
  logic [3:0]  st_be;

  assign is_mem_x   = (inst_x[6:0] == OP_LOAD) || (inst_x[6:0] == OP_STORE);
  assign is_jump_x  = (inst_x[6:0] == OP_JAL) || (inst_x[6:0] == OP_JALR);
  assign is_store_m = (inst_m_q[6:0] == OP_STORE);
  assign a_off      = alu_m_q[1:0];
  assign funct3_m   = inst_m_q[14:12];

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign mis_x = is_mem_x &&
                 (((inst_x[13:12] == 2'b01) && alu_x[0]) ||
                  ((inst_x[13:12] == 2'b10) && (alu_x[1:0] != 2'b00)));
`else
  assign mis_x = 1'b0;
`endif

  assign in_ready       = (state_q == S_IDLE);
  assign dmem_req_valid = (state_q == S_REQ);
  assign dmem_addr      = {alu_m_q[ADDR_W-1:2], 2'b00};
  assign dmem_we        = is_store_m;
  assign dmem_be        = is_store_m ? st_be : 4'b1111;
  assign dmem_wdata     = st_wdata;

  assign out_valid  = out_valid_q;
  assign inst_m     = inst_m_q;
  assign pc_m       = pc_m_q;
  assign alu_m      = alu_m_q;
  assign wb_m       = wb_m_q;
  assign misalign_m = misalign_m_q;
  assign timeout_m  = timeout_m_q;

  // Lane steering: store byte enables/data and load shift by access size.
  // Misaligned low bits are dropped (halfword keeps a[1], word uses 0).
  always_comb begin
    store_data = req_first_q ? (wm_bypass ? wb_w_bypass : rs2_m_q) : sd_q;
    st_be      = 4'b1111;
    st_wdata   = store_data;
    ld_off     = 2'b00;
    unique case (funct3_m[1:0])
      2'b00: begin
        st_be    = 4'b0001 << a_off;
        st_wdata = {4{store_data[7:0]}};
        ld_off   = a_off;
      end
      2'b01: begin
        st_be    = a_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
        ld_off   = {a_off[1], 1'b0};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        ld_off   = 2'b00;
      end
    endcase
  end

  // Load data extraction and sign/zero extension.
  always_comb begin
    ld_shift = dmem_rsp_rdata >> {ld_off, 3'b000};
    unique case (funct3_m)
      3'b000:  ld_fmt = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_fmt = {24'd0, ld_shift[7:0]};
      3'b001:  ld_fmt = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_fmt = {16'd0, ld_shift[15:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/REQ/WAIT FSM.
  always_comb begin
    state_d      = state_q;
    inst_m_d     = inst_m_q;
    pc_m_d       = pc_m_q;
    alu_m_d      = alu_m_q;
    rs2_m_d      = rs2_m_q;
    wb_m_d       = wb_m_q;
    sd_d         = sd_q;
    cnt_d        = cnt_q;
    req_first_d  = req_first_q;
    out_valid_d  = 1'b0;
    misalign_m_d = 1'b0;
    timeout_m_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          inst_m_d = inst_x;
          pc_m_d   = pc_x;
          alu_m_d  = alu_x;
          rs2_m_d  = rs2_x;
          if (is_mem_x && !mis_x) begin
            state_d     = S_REQ;
            req_first_d = 1'b1;
          end else begin
            // A trapped access lands here too; its wb is alu_x (the address).
            out_valid_d  = 1'b1;
            misalign_m_d = mis_x;
            wb_m_d       = is_jump_x ? (pc_x + 32'd4) : alu_x;
          end
        end
      end
      S_REQ: begin
        if (req_first_q) begin
          sd_d = store_data;
        end
        req_first_d = 1'b0;
        if (dmem_req_ready) begin
          if (is_store_m) begin
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          wb_m_d      = ld_fmt;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT - 1)) begin
          wb_m_d      = '0;
          out_valid_d = 1'b1;
          timeout_m_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      inst_m_q     <= 32'h0000_0013;
      pc_m_q       <= '0;
      alu_m_q      <= '0;
      rs2_m_q      <= '0;
      wb_m_q       <= '0;
      sd_q         <= '0;
      cnt_q        <= '0;
      req_first_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      misalign_m_q <= 1'b0;
      timeout_m_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_m_q     <= inst_m_d;
      pc_m_q       <= pc_m_d;
      alu_m_q      <= alu_m_d;
      rs2_m_q      <= rs2_m_d;
      wb_m_q       <= wb_m_d;
      sd_q         <= sd_d;
      cnt_q        <= cnt_d;
      req_first_q  <= req_first_d;
      out_valid_q  <= out_valid_d;
      misalign_m_q <= misalign_m_d;
      timeout_m_q  <= timeout_m_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Testbench for mem_stage_hs: vector tables for non-memory, load and store
// accesses, hand-written timeout/reset/misalign sequences, and a scoreboard
// of expected completions popped whenever out_valid is seen.
module tb_mem_stage_hs;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_x, alu_x, rs2_x, inst_x, wb_w_bypass;
  logic        wm_bypass;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        out_valid;
  logic [31:0] inst_m, pc_m, alu_m, wb_m;
  logic        misalign_m, timeout_m;

  always #5 clk = ~clk;

  mem_stage_hs #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_x(pc_x), .alu_x(alu_x), .rs2_x(rs2_x), .inst_x(inst_x),
    .wb_w_bypass(wb_w_bypass), .wm_bypass(wm_bypass),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_rdata(dmem_rsp_rdata), .out_valid(out_valid),
    .inst_m(inst_m), .pc_m(pc_m), .alu_m(alu_m), .wb_m(wb_m),
    .misalign_m(misalign_m), .timeout_m(timeout_m)
  );

  typedef struct {
    logic [31:0] wb;
    logic        to;
    logic        mis;
    logic        chk_wb;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] inst, pc, alu, wb;
  } nm_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr, rdata, wb;
    string       name;
  } ld_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr, rs2;
    logic        byp;
    logic [31:0] bval;
    int          rdly;
    logic [3:0]  be;
    logic [31:0] wdata;
    string       name;
  } st_vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  function automatic exp_t mkexp(input logic [31:0] wb, input logic to, input logic mis,
                                 input logic chk_wb, input string name);
    exp_t e;
    e.wb = wb; e.to = to; e.mis = mis; e.chk_wb = chk_wb; e.name = name;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rs2);
    in_valid = 1'b1;
    inst_x   = inst;
    pc_x     = pc;
    alu_x    = alu;
    rs2_x    = rs2;
  endtask

  // Completion monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk1("spurious_out_valid", out_valid, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk_wb) chk({mon_e.name, "_wb"}, wb_m, mon_e.wb);
        chk1({mon_e.name, "_timeout"}, timeout_m, mon_e.to);
        chk1({mon_e.name, "_misalign"}, misalign_m, mon_e.mis);
      end
    end
  end

  task automatic do_load(input ld_vec_t v, input int rdly, input int wdly);
    drive(mk(OP_LOAD, v.f3), 32'h200, v.addr, 32'h55);
    sb_q.push_back(mkexp(v.wb, 1'b0, 1'b0, 1'b1, v.name));
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= rdly; k++) begin
      dmem_req_ready = (k == rdly);
      chk1({v.name, "_req_valid"}, dmem_req_valid, 1'b1);
      chk({v.name, "_addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
      chk({v.name, "_be"}, {28'd0, dmem_be}, 32'hF);
      chk1({v.name, "_we"}, dmem_we, 1'b0);
      chk1({v.name, "_in_ready"}, in_ready, 1'b0);
      tick();
    end
    dmem_req_ready = 1'b0;
    for (int k = 0; k < wdly; k++) begin
      chk1({v.name, "_wait_req_valid"}, dmem_req_valid, 1'b0);
      chk1({v.name, "_wait_out_valid"}, out_valid, 1'b0);
      tick();
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = v.rdata;
    tick();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'h5A5A_A5A5;
    chk1({v.name, "_done"}, out_valid, 1'b1);
    chk1({v.name, "_idle"}, in_ready, 1'b1);
  endtask

  task automatic do_store(input st_vec_t v);
    drive(mk(OP_STORE, v.f3), 32'h300, v.addr, v.rs2);
    wm_bypass   = v.byp;
    wb_w_bypass = v.bval;
    sb_q.push_back(mkexp(32'd0, 1'b0, 1'b0, 1'b0, v.name));
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= v.rdly; k++) begin
      dmem_req_ready = (k == v.rdly);
      chk1({v.name, "_req_valid"}, dmem_req_valid, 1'b1);
      chk1({v.name, "_we"}, dmem_we, 1'b1);
      chk({v.name, "_addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
      chk({v.name, "_be"}, {28'd0, dmem_be}, {28'd0, v.be});
      chk({v.name, "_wdata"}, dmem_wdata, v.wdata);
      chk1({v.name, "_in_ready"}, in_ready, 1'b0);
      tick();
      if (k == 0) begin
        // Disturb the store-data sources: later REQ cycles must hold the latched value.
        wm_bypass   = ~wm_bypass;
        wb_w_bypass = 32'h0BAD_0BAD;
      end
    end
    dmem_req_ready = 1'b0;
    wm_bypass      = 1'b0;
    chk1({v.name, "_done"}, out_valid, 1'b1);
    chk1({v.name, "_req_drop"}, dmem_req_valid, 1'b0);
    chk1({v.name, "_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nm_vec_t nm[5];
    ld_vec_t ld[8];
    st_vec_t st[5];

    nm[0] = '{mk(7'b0110011, 3'd0), 32'h0000_0000, 32'h0000_0005, 32'h0000_0005};
    nm[1] = '{mk(7'b1101111, 3'd0), 32'h0000_0100, 32'h0000_0999, 32'h0000_0104};
    nm[2] = '{mk(7'b1100111, 3'd0), 32'hFFFF_FFFC, 32'h0000_0123, 32'h0000_0000};
    nm[3] = '{mk(7'b0010011, 3'd0), 32'h0000_0040, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    nm[4] = '{mk(7'b0110111, 3'd0), 32'h0000_0044, 32'h1234_5000, 32'h1234_5000};

    ld[0] = '{3'b000, 32'h1002, 32'h0080_0000, 32'hFFFF_FF80, "lb_off2"};
    ld[1] = '{3'b100, 32'h1002, 32'h0080_0000, 32'h0000_0080, "lbu_off2"};
    ld[2] = '{3'b001, 32'h1002, 32'h8000_0000, 32'hFFFF_8000, "lh_off2"};
    ld[3] = '{3'b101, 32'h1002, 32'h8000_0000, 32'h0000_8000, "lhu_off2"};
    ld[4] = '{3'b010, 32'h1000, 32'h1234_5678, 32'h1234_5678, "lw"};
    ld[5] = '{3'b000, 32'h1003, 32'h7F00_0000, 32'h0000_007F, "lb_off3"};
    ld[6] = '{3'b000, 32'h1000, 32'h0000_00FF, 32'hFFFF_FFFF, "lb_off0"};
    ld[7] = '{3'b001, 32'h1000, 32'h1234_ABCD, 32'hFFFF_ABCD, "lh_off0"};

    st[0] = '{3'b000, 32'h1003, 32'h0000_00AB, 1'b0, 32'h0,         2, 4'b1000, 32'hABAB_ABAB, "sb_off3"};
    st[1] = '{3'b010, 32'h1004, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, "sw_bypass"};
    st[2] = '{3'b001, 32'h1002, 32'h1234_CAFE, 1'b0, 32'h0,         0, 4'b1100, 32'hCAFE_CAFE, "sh_off2"};
    st[3] = '{3'b000, 32'h1000, 32'h0000_005A, 1'b0, 32'h0,         1, 4'b0001, 32'h5A5A_5A5A, "sb_off0"};
    st[4] = '{3'b001, 32'h1000, 32'h0000_1111, 1'b1, 32'h0000_7777, 2, 4'b0011, 32'h7777_7777, "sh_bypass"};

    reset = 1'b1; in_valid = 1'b0; pc_x = '0; alu_x = '0; rs2_x = '0; inst_x = '0;
    wb_w_bypass = '0; wm_bypass = 1'b0; dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    tick();
    tick();
    chk("rst_inst_m", inst_m, 32'h0000_0013);
    chk("rst_wb_m", wb_m, 32'h0);
    chk("rst_pc_m", pc_m, 32'h0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_req_valid", dmem_req_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    tick();

    // Back-to-back non-memory bundles: one completion per cycle.
    for (int i = 0; i < 5; i++) begin
      drive(nm[i].inst, nm[i].pc, nm[i].alu, 32'h0);
      chk1($sformatf("nm%0d_in_ready", i), in_ready, 1'b1);
      sb_q.push_back(mkexp(nm[i].wb, 1'b0, 1'b0, 1'b1, $sformatf("nm%0d", i)));
      tick();
      chk1($sformatf("nm%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("nm%0d_pc_m", i), pc_m, nm[i].pc);
      chk($sformatf("nm%0d_inst_m", i), inst_m, nm[i].inst);
      chk($sformatf("nm%0d_alu_m", i), alu_m, nm[i].alu);
    end
    in_valid = 1'b0;
    tick();
    chk1("nm_quiet", out_valid, 1'b0);

    for (int i = 0; i < 8; i++) do_load(ld[i], i % 3, i % 4);
    tick();
    for (int i = 0; i < 5; i++) do_store(st[i]);
    tick();

    // Timeout: four silent WAIT cycles abort the load; a late response is ignored.
    drive(mk(OP_LOAD, 3'b010), 32'h500, 32'h3000, 32'h0);
    sb_q.push_back(mkexp(32'h0, 1'b1, 1'b0, 1'b1, "timeout"));
    tick();
    in_valid = 1'b0;
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("to_wait%0d_out_valid", k), out_valid, 1'b0);
      chk1($sformatf("to_wait%0d_in_ready", k), in_ready, 1'b0);
      tick();
    end
    chk1("to_fire", out_valid, 1'b1);
    chk1("to_flag", timeout_m, 1'b1);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h1111_2222;
    tick();
    dmem_rsp_valid = 1'b0;
    chk1("to_late_rsp", out_valid, 1'b0);
    chk1("to_late_idle", in_ready, 1'b1);
    tick();

    // Reset mid-REQ drops the request immediately.
    drive(mk(OP_LOAD, 3'b010), 32'h600, 32'h4000, 32'h0);
    tick();
    in_valid = 1'b0;
    chk1("rreq_req_valid_before", dmem_req_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rreq_req_valid_async", dmem_req_valid, 1'b0);
    chk1("rreq_in_ready_async", in_ready, 1'b1);
    chk("rreq_inst_m", inst_m, 32'h0000_0013);
    tick();
    reset = 1'b0;
    tick();

    // Reset during WAIT; the response that follows must be ignored.
    drive(mk(OP_LOAD, 3'b010), 32'h700, 32'h4004, 32'h0);
    tick();
    in_valid = 1'b0;
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    tick();
    chk1("rwait_busy", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rwait_req_valid", dmem_req_valid, 1'b0);
    chk1("rwait_in_ready", in_ready, 1'b1);
    dmem_rsp_valid = 1'b1;
    tick();
    dmem_rsp_valid = 1'b0;
    chk1("rwait_rsp_ignored", out_valid, 1'b0);
    tick();

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    drive(mk(OP_LOAD, 3'b001), 32'h800, 32'h2001, 32'h0);
    sb_q.push_back(mkexp(32'h2001, 1'b0, 1'b1, 1'b1, "mis_lh"));
    tick();
    in_valid = 1'b0;
    chk1("mis_lh_no_req", dmem_req_valid, 1'b0);
    chk1("mis_lh_done", out_valid, 1'b1);
    chk1("mis_lh_idle", in_ready, 1'b1);
    tick();
    chk1("mis_lh_still_no_req", dmem_req_valid, 1'b0);
    drive(mk(OP_STORE, 3'b010), 32'h804, 32'h2002, 32'h0);
    sb_q.push_back(mkexp(32'h2002, 1'b0, 1'b1, 1'b1, "mis_sw"));
    tick();
    in_valid = 1'b0;
    chk1("mis_sw_no_req", dmem_req_valid, 1'b0);
    chk1("mis_sw_done", out_valid, 1'b1);
    tick();
`else
    begin
      ld_vec_t u;
      st_vec_t s;
      u = '{3'b001, 32'h2001, 32'h8765_4321, 32'h0000_4321, "lh_unaligned"};
      do_load(u, 0, 0);
      u = '{3'b010, 32'h2002, 32'hAABB_CCDD, 32'hAABB_CCDD, "lw_unaligned"};
      do_load(u, 1, 1);
      s = '{3'b001, 32'h2003, 32'h0000_BEEF, 1'b0, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF, "sh_unaligned"};
      do_store(s);
      tick();
    end
`endif

    tick();
    chk("sb_drain", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
